// File: rtl/mmm_pkg.sv
// Shared core-wide constants.
package mmm_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing signals of branch_resolve_queue.
interface branch_resolve_queue_if;
    import mmm_pkg::XLEN;

    logic            flush_i;
    logic            push_valid_i;
    logic            push_ready_o;
    logic [XLEN-1:0] push_pc_i;
    logic            push_taken_i;
    logic [XLEN-1:0] push_target_i;
    logic            ex_valid_i;
    logic            ex_ready_o;
    logic            ex_taken_i;
    logic [XLEN-1:0] ex_target_i;
    logic            res_valid_o;
    logic [XLEN-1:0] res_pc_o;
    logic            res_taken_o;
    logic            mispredict_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output flush_i, push_valid_i, push_pc_i, push_taken_i, push_target_i,
        output ex_valid_i, ex_taken_i, ex_target_i,
        input  push_ready_o, ex_ready_o,
        input  res_valid_o, res_pc_o, res_taken_o, mispredict_o, redirect_pc_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_pc_i, push_taken_i, push_target_i,
        input  ex_valid_i, ex_taken_i, ex_target_i,
        output push_ready_o, ex_ready_o,
        output res_valid_o, res_pc_o, res_taken_o, mispredict_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; retires the head on resolution and squashes on mispredict.
// Optional BRQ_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    branch_resolve_queue_if.slave     bus,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]               n_branches_o,
    output logic [31:0]               n_mispred_o
`endif
);
    import mmm_pkg::XLEN;

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [XLEN-1:0]  pc_q     [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [DEPTH-1:0] taken_q;

    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] res_pc_q, res_pc_d;
    logic            res_taken_q, res_taken_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_q, redirect_d;

    logic            full, empty, push_fire, pop_fire, mispred_now;
    logic [IdxW-1:0] ridx, widx;
    logic [XLEN-1:0] head_pc, head_target, redirect_now;
    logic            head_taken;

    assign ridx        = rptr_q[IdxW-1:0];
    assign widx        = wptr_q[IdxW-1:0];
    assign full        = (ridx == widx) && (rptr_q[IdxW] != wptr_q[IdxW]);
    assign empty       = (rptr_q == wptr_q);
    assign push_fire   = bus.push_valid_i && !full;
    assign pop_fire    = bus.ex_valid_i && !empty;
    assign head_pc     = pc_q[ridx];
    assign head_target = target_q[ridx];
    assign head_taken  = taken_q[ridx];

    assign mispred_now  = pop_fire && ((head_taken != bus.ex_taken_i) ||
                          (bus.ex_taken_i && (head_target != bus.ex_target_i)));
    assign redirect_now = bus.ex_taken_i ? bus.ex_target_i : head_pc + XLEN'(4);

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        res_valid_d  = 1'b0;
        mispredict_d = 1'b0;
        res_pc_d     = res_pc_q;
        res_taken_d  = res_taken_q;
        redirect_d   = redirect_q;
        if (bus.flush_i) begin
            wptr_d      = '0;
            rptr_d      = '0;
            res_pc_d    = '0;
            res_taken_d = 1'b0;
            redirect_d  = '0;
        end else begin
            if (pop_fire) begin
                rptr_d       = rptr_q + PtrW'(1);
                res_valid_d  = 1'b1;
                res_pc_d     = head_pc;
                res_taken_d  = bus.ex_taken_i;
                mispredict_d = mispred_now;
                redirect_d   = redirect_now;
            end
            // A mispredict empties the queue, dropping any same-cycle wrong-path push.
            if (mispred_now) begin
                wptr_d = rptr_d;
            end else if (push_fire) begin
                wptr_d = wptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            res_valid_q  <= 1'b0;
            res_pc_q     <= '0;
            res_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            res_valid_q  <= res_valid_d;
            res_pc_q     <= res_pc_d;
            res_taken_q  <= res_taken_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_fire && !bus.flush_i && !mispred_now) begin
            pc_q[widx]     <= bus.push_pc_i;
            target_q[widx] <= bus.push_target_i;
            taken_q[widx]  <= bus.push_taken_i;
        end
    end

    assign bus.push_ready_o  = !full;
    assign bus.ex_ready_o    = !empty;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_pc_o      = res_pc_q;
    assign bus.res_taken_o   = res_taken_q;
    assign bus.mispredict_o  = mispredict_q;
    assign bus.redirect_pc_o = redirect_q;
    assign count_o           = wptr_q - rptr_q;
    assign empty_o           = empty;

`ifdef BRQ_STATS_EN
    logic [31:0] n_branches_q, n_mispred_q;
    logic        pop_eff;

    assign pop_eff = pop_fire && !bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_branches_q <= '0;
            n_mispred_q  <= '0;
        end else begin
            if (pop_eff && (n_branches_q != '1)) n_branches_q <= n_branches_q + 32'd1;
            if (pop_eff && mispred_now && (n_mispred_q != '1)) n_mispred_q <= n_mispred_q + 32'd1;
        end
    end

    assign n_branches_o = n_branches_q;
    assign n_mispred_o  = n_mispred_q;
`endif
endmodule
